// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Synchronises/debounces the reset button, qualifies PLL lock and
//            drives a stretched soc reset plus clock enable.
//            Optional lock watchdog enabled by defining RST_SEQ_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int          SYNC_STAGES         = 2,
    parameter logic [15:0] DEBOUNCE_CYCLES     = 16'd27000,
    parameter logic [15:0] LOCK_STABLE_CYCLES  = 16'd1024,
    parameter logic [7:0]  RESET_CYCLES        = 8'd64,
    parameter logic [23:0] LOCK_TIMEOUT_CYCLES = 24'd2700000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reset_button_n,
    input  logic       pll_locked,
    output logic       soc_rst,
    output logic       soc_clk_en,
    output logic [1:0] seq_state,
    output logic       lock_timeout
);

    localparam logic [1:0] S_WAIT_LOCK   = 2'd0;
    localparam logic [1:0] S_LOCK_STABLE = 2'd1;
    localparam logic [1:0] S_RESET       = 2'd2;
    localparam logic [1:0] S_RUN         = 2'd3;

    logic [SYNC_STAGES-1:0] r_btn_sync;
    logic [SYNC_STAGES-1:0] r_lk_sync;
    logic                   w_btn_s;
    logic                   w_lk_s;

    logic        r_db_level;
    logic [15:0] r_db_cnt;
    logic        w_db_flip;
    logic        w_press;

    logic [1:0]  r_state;
    logic [15:0] r_lock_cnt;
    logic [7:0]  r_rst_cnt;
    logic        r_soc_rst;
    logic        r_soc_clk_en;

    // Chains reset to the inactive levels so nothing is released early
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_sync <= '1;
            r_lk_sync  <= '0;
        end else begin
            r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], reset_button_n};
            r_lk_sync  <= {r_lk_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_btn_s = r_btn_sync[SYNC_STAGES-1];
    assign w_lk_s  = r_lk_sync[SYNC_STAGES-1];

    assign w_db_flip = (w_btn_s != r_db_level) && (r_db_cnt == DEBOUNCE_CYCLES - 16'd1);
    assign w_press   = w_db_flip && r_db_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_level <= 1'b1;
            r_db_cnt   <= '0;
        end else if (w_btn_s == r_db_level) begin
            r_db_cnt <= '0;
        end else if (w_db_flip) begin
            r_db_level <= ~r_db_level;
            r_db_cnt   <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 16'd1;
        end
    end

    // Lock loss outranks everything, including a press in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_WAIT_LOCK;
            r_lock_cnt   <= '0;
            r_rst_cnt    <= '0;
            r_soc_rst    <= 1'b1;
            r_soc_clk_en <= 1'b0;
        end else begin
            r_soc_rst    <= (r_state != S_RUN);
            r_soc_clk_en <= (r_state == S_RUN);
            if (!w_lk_s) begin
                r_state    <= S_WAIT_LOCK;
                r_lock_cnt <= '0;
                r_rst_cnt  <= '0;
            end else begin
                case (r_state)
                    S_WAIT_LOCK: begin
                        r_lock_cnt <= '0;
                        r_state    <= S_LOCK_STABLE;
                    end
                    S_LOCK_STABLE: begin
                        if (r_lock_cnt == LOCK_STABLE_CYCLES - 16'd1) begin
                            r_lock_cnt <= '0;
                            r_rst_cnt  <= '0;
                            r_state    <= S_RESET;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + 16'd1;
                        end
                    end
                    S_RESET: begin
                        if (w_press) begin
                            r_rst_cnt <= '0;
                        end else if (r_rst_cnt == RESET_CYCLES - 8'd1) begin
                            r_state <= S_RUN;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + 8'd1;
                        end
                    end
                    default: begin
                        if (w_press) begin
                            r_rst_cnt <= '0;
                            r_state   <= S_RESET;
                        end
                    end
                endcase
            end
        end
    end

    assign soc_rst    = r_soc_rst;
    assign soc_clk_en = r_soc_clk_en;
    assign seq_state  = r_state;

`ifdef RST_SEQ_WDOG_EN
    logic [23:0] r_wdog_cnt;
    logic        r_lock_timeout;

    // Counts only while waiting for a qualified lock; flag is sticky until rst
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog_cnt     <= '0;
            r_lock_timeout <= 1'b0;
        end else if ((r_state == S_WAIT_LOCK) || (r_state == S_LOCK_STABLE)) begin
            if (r_wdog_cnt == LOCK_TIMEOUT_CYCLES - 24'd1) begin
                r_lock_timeout <= 1'b1;
            end else begin
                r_wdog_cnt <= r_wdog_cnt + 24'd1;
            end
        end else begin
            r_wdog_cnt <= '0;
        end
    end

    assign lock_timeout = r_lock_timeout;
`else
    logic w_unused_wdog;
    assign w_unused_wdog = ^LOCK_TIMEOUT_CYCLES;
    assign lock_timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits between the board-level PLL/reset inputs and the soc instance.
- Synchronises and debounces the active-low reset button and qualifies the PLL lock signal.
- Drives a clean, stretched, active-high soc reset plus a clock enable. The soc therefore needs no combinational clock gating.
- Runs in the PLL output clock domain.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronisers on reset_button_n and pll_locked (legal values 2..4).
- DEBOUNCE_CYCLES, 16'd27000, consecutive stable cycles required before a button level change is accepted (≥ 2).
- LOCK_STABLE_CYCLES, 16'd1024, consecutive cycles pll_locked must stay high before the soc is released from reset.
- RESET_CYCLES, 8'd64, cycles soc_rst is held after lock is qualified or after a button press (≥ 1).
- LOCK_TIMEOUT_CYCLES, 24'd2700000, watchdog limit; used only when RST_SEQ_WDOG_EN is defined.

Ports:
- clk  input  1  PLL output clock; only clock in the block.
- rst  input  1  Synchronous, active-high reset for this block (power-on source).
- reset_button_n  input  1  Raw, asynchronous, active-low push button.
- pll_locked  input  1  Raw, asynchronous PLL lock indicator.
- soc_rst  output  1  Active-high reset to soc; registered.
- soc_clk_en  output  1  Clock enable to soc; high only in RUN; registered.
- seq_state  output  2  Current FSM state, for LEDs/debug: 0 WAIT_LOCK, 1 LOCK_STABLE, 2 RESET, 3 RUN.
- lock_timeout  output  1  Sticky watchdog flag; constant 0 when the watchdog is compiled out.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=WAIT_LOCK, soc_rst=1, soc_clk_en=0, lock_timeout=0.
  - All counters = 0.
  - Synchroniser chains are loaded with the inactive values: button=1, lock=0.
  - Debounced button level = 1 (released).
- Synchronisers: each raw input passes through SYNC_STAGES flip-flops. All logic below uses the synchronised values only.
- Debounce:
  - Counter increments while the synchronised button differs from the debounced level.
  - It clears whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - A press event is a 1-cycle pulse on a debounced 1→0 transition. The release transition generates no event.
- FSM states and transitions:
  - WAIT_LOCK: the lock counter is cleared. On lk_s=1, go to LOCK_STABLE.
  - LOCK_STABLE: the lock counter increments each cycle. If lk_s=0, return to WAIT_LOCK. When the counter reaches LOCK_STABLE_CYCLES-1, clear it and go to RESET.
  - RESET: the reset counter increments each cycle. When it reaches RESET_CYCLES-1, go to RUN. A press event restarts the reset counter at 0.
  - RUN: on a press event, go to RESET with the reset counter at 0.
  - Any state: lk_s=0 forces WAIT_LOCK next cycle. This has priority over a press event in the same cycle.
- Output registers:
  - soc_rst = 1 in every state except RUN.
  - soc_clk_en = 1 only in RUN.
  - Both update on the same edge as the state register, so they change in the cycle after the state changes.
  - Neither output ever glitches; both are registered.
- Latency:
  - lock rising edge at the pin → soc_rst falling = SYNC_STAGES + 1 + LOCK_STABLE_CYCLES + RESET_CYCLES cycles (±1).
  - RESET lasts exactly RESET_CYCLES cycles with soc_rst=1.
  - Lock loss → soc_rst=1 within SYNC_STAGES + 2 cycles.
- Counter widths match their parameter widths. Counters saturate and do not wrap.
- rst asserted mid-sequence returns the block to the reset values on the next edge, regardless of state.

Optional Feature:
- Macro: RST_SEQ_WDOG_EN.
- When defined:
  - A 24-bit watchdog counts cycles spent in WAIT_LOCK or LOCK_STABLE.
  - It clears on entry to RESET.
  - On reaching LOCK_TIMEOUT_CYCLES-1, lock_timeout sets and stays set until rst. The counter saturates.
  - The FSM behaviour is unchanged.
- When undefined: no watchdog logic is built, and lock_timeout is tied to 0.

Test Plan (use DEBOUNCE_CYCLES=4, LOCK_STABLE_CYCLES=8, RESET_CYCLES=5, SYNC_STAGES=2):
- Power-up: rst high for 3 cycles, then pll_locked=1 → soc_rst=1 and soc_clk_en=0 until about 2+1+8+5 cycles after lock; then soc_rst=0, soc_clk_en=1, seq_state=3.
- Lock glitch: in LOCK_STABLE, drop pll_locked for 1 cycle at count 5 → state returns to WAIT_LOCK; full 8-cycle qualification restarts; soc_rst never drops.
- Button bounce: in RUN, toggle reset_button_n 0/1 every 2 cycles for 20 cycles → no press event; soc_rst stays 0. Then hold low for 6 cycles → soc_rst=1 for exactly 5 cycles, then RUN.
- Lock loss plus press in the same cycle while in RUN → state=WAIT_LOCK, soc_rst=1, soc_clk_en=0 within 4 cycles.
- Mid-operation rst: assert rst during RESET at count 3 → next edge gives seq_state=0, soc_rst=1, all counters 0.
- RST_SEQ_WDOG_EN with LOCK_TIMEOUT_CYCLES=20 and pll_locked held 0 → lock_timeout=1 at cycle 20 and stays 1 after a later lock. Without the macro → lock_timeout stays 0.
